rm_lane_sched: RTL and testbench
================================

RM_LANE_SCHED -- requirements
Module: rm_lane_sched

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 4, number of event sources sharing one lane.
REQ-002 SHALL have parameters: NUM_EVENTS, default 6, lane event vector width.
REQ-003 SHALL have parameters: NUM_RULES, default 10, lane monitor output width.
REQ-004 SHALL have parameters: SLICE_LEN, default 16, maximum RUN cycles per grant while another source is pending (>=2).
REQ-005 SHALL have parameters: MON_LAT, default 2, cycles from lane_vector_o to the corresponding monitor_i (>=1).
REQ-006 SHALL have ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- req_i  in  NUM_REQ  per-source request.
- req_vector_i  in  NUM_REQ*NUM_EVENTS  source k event vector at bits [k*NUM_EVENTS +: NUM_EVENTS].
- gnt_o  out  NUM_REQ  one-hot grant.
- lane_vector_o  out  NUM_EVENTS  event vector to the lane.
- lane_reset_o  out  1  lane reset, active-high.
- monitor_i  in  NUM_RULES  lane rule-violation bits.
- viol_valid_o  out  1  violation record valid.
- viol_ready_i  in  1  consumer accepts the record.
- viol_id_o  out  $clog2(NUM_REQ)  source owning the violation.
- viol_rules_o  out  NUM_RULES  captured monitor_i.
- viol_ovf_o  out  1  sticky: a violation was dropped.

Function
REQ-007 SHALL implement FSM states IDLE, LRST, RUN, DRAIN; all outputs registered.
REQ-008 IDLE: when any req_i bit is set, SHALL select owner by round-robin starting at rr_ptr, then go to LRST; otherwise stay in IDLE.
REQ-009 LRST: SHALL assert lane_reset_o for exactly 1 cycle with gnt_o=0 and lane_vector_o=0, then go to RUN.
REQ-010 RUN: SHALL drive gnt_o[owner]=1 and lane_vector_o=req_vector_i slice of owner, registered, so output is 1 cycle after the input.
REQ-011 RUN: SHALL keep slice counter cnt, cleared on entry and incremented each RUN cycle.
REQ-012 RUN exit: req_i[owner]=0 SHALL cause exit to DRAIN; the gnt_o and vector drop in the same cycle as DRAIN entry.
REQ-013 RUN exit: cnt==SLICE_LEN-1 with any other req_i set SHALL cause exit to DRAIN.
REQ-014 RUN: cnt==SLICE_LEN-1 with no other request SHALL wrap cnt to 0 and stay in RUN.
REQ-015 DRAIN: SHALL hold gnt_o=0 and lane_vector_o=0 for exactly MON_LAT cycles, then go to IDLE.
REQ-016 DRAIN exit to IDLE SHALL set rr_ptr=(owner+1) mod NUM_REQ.
REQ-017 Requests arriving in LRST/RUN/DRAIN SHALL wait for IDLE; req_i changes of non-owners never affect the current owner.
REQ-018 Violation detect: in RUN or DRAIN, monitor_i!=0 is a violation attributed to owner; monitor_i SHALL be ignored in IDLE and LRST.
REQ-019 Capture: a violation while viol_valid_o=0 or the handshake (viol_valid_o && viol_ready_i) fires SHALL load viol_id_o=owner, viol_rules_o=monitor_i, viol_valid_o=1 next cycle.
REQ-020 Overflow: a violation while viol_valid_o=1 and viol_ready_i=0 SHALL drop it, hold the stored record unchanged and set viol_ovf_o=1.
REQ-021 viol_valid_o SHALL clear the cycle after a handshake when there is no new capture.
REQ-022 Record stability: viol_id_o and viol_rules_o SHALL stay stable while viol_valid_o=1 and not accepted.
REQ-023 viol_ovf_o SHALL clear only on reset.

Reset
REQ-024 rst_ni=0 at a clock edge SHALL, from any state including mid-RUN, force IDLE next cycle.
REQ-025 Reset SHALL set rr_ptr=0, cnt=0, gnt_o=0, lane_vector_o=0, lane_reset_o=1.
REQ-026 Reset SHALL set viol_valid_o=0, viol_id_o=0, viol_rules_o=0, viol_ovf_o=0.
REQ-027 lane_reset_o SHALL fall to 0 the first cycle after rst_ni=1 unless in LRST.

Verification
REQ-028 Single source: req_i=0001 with a constant vector 6'h2A -> lane_reset_o pulses 1 cycle, gnt_o=0001, and lane_vector_o=2A from the following cycle.
REQ-029 Slicing: req_i=0011 held -> source0 gets exactly 16 RUN cycles, 2 DRAIN, 1 IDLE, 1 LRST, then gnt_o=0010.
REQ-030 Round-robin wrap: source3 finishes with req_i=1001 -> next grant is source0; rr_ptr wraps 3->0.
REQ-031 Lone owner: req_i=0100 held 40 cycles -> cnt wraps, no DRAIN, gnt_o stays 0100.
REQ-032 Violations: monitor_i=10'h005 in RUN (owner 2) with viol_ready_i=0 -> record {2,005}; second violation 10'h100 -> viol_ovf_o=1 and record stays {2,005}.
REQ-033 Reset mid-RUN: assert rst_ni=0 at cnt=7 -> next cycle gnt_o=0, lane_reset_o=1, viol_valid_o=0, and the next grant starts at source0.

Source files
------------

// File: rtl/rm_lane_sched.sv
// rm_lane_sched: time-slices one shared lane between NUM_REQ event sources.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; next owner chosen round-robin starting at rr_ptr
// LRST  | one-cycle lane reset pulse before the new owner drives it
// RUN   | owner's event vector forwarded to the lane; cnt is the slice count
// DRAIN | lane quiet for MON_LAT cycles so late monitor hits reach the owner
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_i, req_vector_i    per-source request and packed event vectors
//   gnt_o                  one-hot grant (RUN only)
//   lane_vector_o          registered copy of the owner's event vector
//   lane_reset_o           active-high lane reset
//   monitor_i              lane rule-violation bits
//   viol_valid_o/ready_i   violation record handshake
//   viol_id_o, viol_rules_o  owner and captured monitor bits
//   viol_ovf_o             sticky: a violation was dropped
module rm_lane_sched #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_EVENTS = 6,
  parameter int NUM_RULES  = 10,
  parameter int SLICE_LEN  = 16,
  parameter int MON_LAT    = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*NUM_EVENTS-1:0]   req_vector_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_EVENTS-1:0]           lane_vector_o,
  output logic                            lane_reset_o,
  input  logic [NUM_RULES-1:0]            monitor_i,
  output logic                            viol_valid_o,
  input  logic                            viol_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]      viol_id_o,
  output logic [NUM_RULES-1:0]            viol_rules_o,
  output logic                            viol_ovf_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(SLICE_LEN);
  localparam int DRN_W = (MON_LAT > 1) ? $clog2(MON_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LRST, S_RUN, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DRN_W-1:0]       drn_q, drn_d;
  logic [NUM_REQ-1:0]     gnt_d;
  logic [NUM_EVENTS-1:0]  vec_d;
  logic                   lrst_d;

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the
  // lowest set bit, then rotate the offset back.
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [NUM_REQ-1:0]     req_rot;
  logic [ID_W-1:0]        pick_off;
  logic                   pick_vld;
  logic [ID_W:0]          pick_sum;
  logic [ID_W-1:0]        pick;

  assign req_dbl  = {req_i, req_i};
  assign req_rot  = req_dbl[rr_ptr_q +: NUM_REQ];

  always_comb begin
    pick_off = '0;
    pick_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_off = ID_W'(i);
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
  assign pick     = ID_W'((pick_sum >= (ID_W+1)'(NUM_REQ)) ?
                          (pick_sum - (ID_W+1)'(NUM_REQ)) : pick_sum);

  logic [NUM_REQ-1:0]     own_oh;
  logic                   others_req;
  logic [NUM_EVENTS-1:0]  own_vec;
  logic                   slice_end;
  logic                   viol;

  assign own_oh     = NUM_REQ'(1) << owner_q;
  assign others_req = |(req_i & ~own_oh);
  assign own_vec    = req_vector_i[owner_q*NUM_EVENTS +: NUM_EVENTS];
  assign slice_end  = (cnt_q == CNT_W'(SLICE_LEN - 1));
  assign viol       = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (|monitor_i);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    drn_d    = drn_q;
    gnt_d    = '0;
    vec_d    = '0;
    lrst_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          state_d = S_LRST;
          lrst_d  = 1'b1;
        end
      end
      S_LRST: begin
        state_d = S_RUN;
        cnt_d   = '0;
        gnt_d   = own_oh;
        vec_d   = own_vec;
      end
      S_RUN: begin
        if (!req_i[owner_q] || (slice_end && others_req)) begin
          state_d = S_DRAIN;
          drn_d   = DRN_W'(MON_LAT - 1);
        end else begin
          // A lone owner keeps the lane; the slice count just wraps.
          cnt_d = slice_end ? '0 : cnt_q + 1'b1;
          gnt_d = own_oh;
          vec_d = own_vec;
        end
      end
      S_DRAIN: begin
        if (drn_q == '0) begin
          state_d  = S_IDLE;
          rr_ptr_d = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else begin
          drn_d = drn_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      drn_q         <= '0;
      gnt_o         <= '0;
      lane_vector_o <= '0;
      lane_reset_o  <= 1'b1;
      viol_valid_o  <= 1'b0;
      viol_id_o     <= '0;
      viol_rules_o  <= '0;
      viol_ovf_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      drn_q         <= drn_d;
      gnt_o         <= gnt_d;
      lane_vector_o <= vec_d;
      lane_reset_o  <= lrst_d;
      if (viol) begin
        if (!viol_valid_o || viol_ready_i) begin
          viol_valid_o <= 1'b1;
          viol_id_o    <= owner_q;
          viol_rules_o <= monitor_i;
        end else begin
          viol_ovf_o   <= 1'b1;
        end
      end else if (viol_valid_o && viol_ready_i) begin
        viol_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rm_lane_sched.sv
module tb_rm_lane_sched;
  localparam int NR  = 4;
  localparam int NE  = 6;
  localparam int NRU = 10;
  localparam int SL  = 16;
  localparam int ML  = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [NR-1:0]   req_i = '0;
  logic [NR*NE-1:0] req_vector_i = '0;
  logic [NRU-1:0]  monitor_i = '0;
  logic            viol_ready_i = 1'b0;
  logic [NR-1:0]   gnt_o;
  logic [NE-1:0]   lane_vector_o;
  logic            lane_reset_o;
  logic            viol_valid_o;
  logic [1:0]      viol_id_o;
  logic [NRU-1:0]  viol_rules_o;
  logic            viol_ovf_o;

  rm_lane_sched #(.NUM_REQ(NR), .NUM_EVENTS(NE), .NUM_RULES(NRU),
                  .SLICE_LEN(SL), .MON_LAT(ML)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .req_vector_i(req_vector_i),
    .gnt_o(gnt_o), .lane_vector_o(lane_vector_o), .lane_reset_o(lane_reset_o),
    .monitor_i(monitor_i), .viol_valid_o(viol_valid_o), .viol_ready_i(viol_ready_i),
    .viol_id_o(viol_id_o), .viol_rules_o(viol_rules_o), .viol_ovf_o(viol_ovf_o));

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [24:0] dut_bus;
  logic [24:0] exp_bus;
  assign dut_bus = {gnt_o, lane_vector_o, lane_reset_o, viol_valid_o,
                    viol_id_o, viol_rules_o, viol_ovf_o};

  // Reference model: phase 0 idle, 1 lane reset, 2 running, 3 draining.
  int          m_ph, m_own, m_rr, m_cnt, m_dl, e_id;
  logic [NE-1:0] m_vec;
  logic        m_lrst, e_valid, e_ovf;
  logic [NRU-1:0] e_rules;

  task automatic model_step(input logic r, input logic [NR-1:0] q,
                            input logic [NR*NE-1:0] v, input logic [NRU-1:0] mon,
                            input logic rdy);
    bit found;
    if (!r) begin
      m_ph = 0; m_own = 0; m_rr = 0; m_cnt = 0; m_dl = 0; m_vec = '0;
      m_lrst = 1'b1; e_valid = 1'b0; e_id = 0; e_rules = '0; e_ovf = 1'b0;
    end else begin
      if ((m_ph == 2 || m_ph == 3) && mon != '0) begin
        if (!e_valid || rdy) begin
          e_valid = 1'b1; e_id = m_own; e_rules = mon;
        end else e_ovf = 1'b1;
      end else if (e_valid && rdy) e_valid = 1'b0;
      case (m_ph)
        0: begin
          found = 0;
          for (int k = 0; k < NR; k++)
            if (!found && q[(m_rr + k) % NR]) begin found = 1; m_own = (m_rr + k) % NR; end
          if (found) m_ph = 1;
        end
        1: begin m_ph = 2; m_cnt = 0; m_vec = v[m_own*NE +: NE]; end
        2: begin
          if (!q[m_own] || (m_cnt == SL - 1 && (q & ~(NR'(1) << m_own)) != '0)) begin
            m_ph = 3; m_dl = ML;
          end else begin
            m_cnt = (m_cnt + 1) % SL; m_vec = v[m_own*NE +: NE];
          end
        end
        default: begin
          m_dl--;
          if (m_dl == 0) begin m_ph = 0; m_rr = (m_own + 1) % NR; end
        end
      endcase
      m_lrst = (m_ph == 1);
    end
    exp_bus = {(m_ph == 2) ? NR'(1) << m_own : NR'(0), (m_ph == 2) ? m_vec : NE'(0),
               m_lrst, e_valid, 2'(e_id), e_rules, e_ovf};
  endtask

  task automatic cycle();
    logic r, rdy;
    logic [NR-1:0] q;
    logic [NR*NE-1:0] v;
    logic [NRU-1:0] mon;
    r = rst_ni; q = req_i; v = req_vector_i; mon = monitor_i; rdy = viol_ready_i;
    @(posedge clk_i);
    model_step(r, q, v, mon, rdy);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; req_i = '0; monitor_i = '0; viol_ready_i = 1'b0;
    cycle();
    rst_ni = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_i = '0; monitor_i = '0; viol_ready_i = 1'b0;
    repeat (2) cycle();
    checks++;
    if (gnt_o !== '0 || lane_vector_o !== '0 || lane_reset_o !== 1'b1) begin
      errors++; $display("FAIL reset_lane gnt=%b vec=%h lrst=%b exp 0000/00/1", gnt_o, lane_vector_o, lane_reset_o);
    end
    checks++;
    if ({viol_valid_o, viol_id_o, viol_rules_o, viol_ovf_o} !== 14'h0) begin
      errors++; $display("FAIL reset_viol got=%h exp=0", {viol_valid_o, viol_id_o, viol_rules_o, viol_ovf_o});
    end
    checks++;
    if (dut_bus !== exp_bus) begin errors++; $display("FAIL model_reset dut=%h exp=%h", dut_bus, exp_bus); end
    rst_ni = 1'b1;
    cycle();
    checks++;
    if (lane_reset_o !== 1'b0) begin errors++; $display("FAIL reset_release lrst=%b exp 0", lane_reset_o); end
  endtask

  task automatic test_single_source();
    req_vector_i = {$urandom, $urandom};
    req_vector_i[5:0] = 6'h2A;
    req_i = 4'b0001;
    cycle();
    checks++;
    if (lane_reset_o !== 1'b1 || gnt_o !== 4'b0000) begin
      errors++; $display("FAIL single_lrst lrst=%b gnt=%b exp 1/0000", lane_reset_o, gnt_o);
    end
    cycle();
    checks++;
    if (lane_reset_o !== 1'b0 || gnt_o !== 4'b0001 || lane_vector_o !== 6'h2A) begin
      errors++; $display("FAIL single_run lrst=%b gnt=%b vec=%h exp 0/0001/2a", lane_reset_o, gnt_o, lane_vector_o);
    end
    for (int c = 0; c < 10; c++) begin
      req_vector_i[NR*NE-1:NE] = 18'($urandom);
      if (c == 5) req_i = 4'b0000;
      cycle();
      checks++;
      if (dut_bus !== exp_bus) begin errors++; $display("FAIL model_single c=%0d dut=%h exp=%h", c, dut_bus, exp_bus); end
    end
  endtask

  task automatic test_slicing();
    int n0, gap;
    bit seen1;
    n0 = 0; gap = 0; seen1 = 0;
    do_reset();
    req_vector_i = {$urandom, $urandom};
    req_i = 4'b0011;
    for (int c = 0; c < 40; c++) begin
      cycle();
      checks++;
      if (dut_bus !== exp_bus) begin errors++; $display("FAIL model_slice c=%0d dut=%h exp=%h", c, dut_bus, exp_bus); end
      if (!seen1) begin
        if (gnt_o == 4'b0001) n0++;
        else if (n0 > 0) begin
          if (gnt_o == 4'b0010) seen1 = 1; else gap++;
        end
      end
    end
    checks++;
    if (n0 !== SL) begin errors++; $display("FAIL slice_len got=%0d exp=%0d", n0, SL); end
    checks++;
    if (!seen1 || gap !== ML + 2) begin errors++; $display("FAIL slice_gap got=%0d seen=%0d exp=%0d", gap, seen1, ML + 2); end
  endtask

  task automatic test_rr_wrap();
    int waited;
    bit got;
    do_reset();
    req_i = 4'b1000;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      if (gnt_o == 4'b1000) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rr_first gnt=%b exp 1000 (timeout)", gnt_o); end
    req_i = 4'b1001;
    got = 0; waited = 0;
    while (!got && waited < 60) begin
      cycle(); waited++;
      checks++;
      if (dut_bus !== exp_bus) begin errors++; $display("FAIL model_rr dut=%h exp=%h", dut_bus, exp_bus); end
      if (gnt_o != 4'b0000 && gnt_o != 4'b1000) got = 1;
    end
    checks++;
    if (gnt_o !== 4'b0001) begin errors++; $display("FAIL rr_wrap gnt=%b exp 0001", gnt_o); end
  endtask

  task automatic test_lone_owner();
    bit got;
    do_reset();
    req_i = 4'b0100;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      if (gnt_o == 4'b0100) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL lone_first gnt=%b exp 0100 (timeout)", gnt_o); end
    for (int c = 0; c < 40; c++) begin
      req_vector_i = {$urandom, $urandom};
      cycle();
      checks++;
      if (gnt_o !== 4'b0100) begin errors++; $display("FAIL lone_hold c=%0d gnt=%b exp 0100", c, gnt_o); end
    end
  endtask

  task automatic test_violations();
    bit got;
    do_reset();
    viol_ready_i = 1'b0;
    monitor_i = 10'h3FF;
    cycle();
    req_i = 4'b0100;
    repeat (2) cycle();
    monitor_i = '0;
    checks++;
    if (viol_valid_o !== 1'b0) begin errors++; $display("FAIL viol_ignored valid=%b exp 0", viol_valid_o); end
    got = (gnt_o == 4'b0100);
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      if (gnt_o == 4'b0100) got = 1;
    end
    monitor_i = 10'h005;
    cycle();
    monitor_i = '0;
    cycle();
    checks++;
    if ({viol_valid_o, viol_id_o, viol_rules_o, viol_ovf_o} !== {1'b1, 2'd2, 10'h005, 1'b0}) begin
      errors++; $display("FAIL viol_capture v=%b id=%0d rules=%h ovf=%b exp 1/2/005/0",
                         viol_valid_o, viol_id_o, viol_rules_o, viol_ovf_o);
    end
    monitor_i = 10'h100;
    cycle();
    monitor_i = '0;
    cycle();
    checks++;
    if ({viol_valid_o, viol_id_o, viol_rules_o, viol_ovf_o} !== {1'b1, 2'd2, 10'h005, 1'b1}) begin
      errors++; $display("FAIL viol_ovf v=%b id=%0d rules=%h ovf=%b exp 1/2/005/1",
                         viol_valid_o, viol_id_o, viol_rules_o, viol_ovf_o);
    end
    viol_ready_i = 1'b1;
    cycle();
    viol_ready_i = 1'b0;
    checks++;
    if (viol_valid_o !== 1'b0 || viol_ovf_o !== 1'b1) begin
      errors++; $display("FAIL viol_accept valid=%b ovf=%b exp 0/1", viol_valid_o, viol_ovf_o);
    end
    checks++;
    if (dut_bus !== exp_bus) begin errors++; $display("FAIL model_viol dut=%h exp=%h", dut_bus, exp_bus); end
  endtask

  task automatic test_reset_mid_run();
    bit got;
    do_reset();
    req_i = 4'b0001;
    repeat (3) cycle();
    req_i = 4'b0000;
    repeat (5) cycle();
    req_i = 4'b0011;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      if (gnt_o == 4'b0010) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL mid_owner1 gnt=%b exp 0010 (timeout)", gnt_o); end
    monitor_i = 10'h001;
    cycle();
    monitor_i = '0;
    repeat (6) cycle();
    rst_ni = 1'b0;
    cycle();
    checks++;
    if (gnt_o !== 4'b0000 || lane_reset_o !== 1'b1 || viol_valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset gnt=%b lrst=%b valid=%b exp 0000/1/0", gnt_o, lane_reset_o, viol_valid_o);
    end
    rst_ni = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      if (gnt_o != 4'b0000) got = 1;
    end
    checks++;
    if (gnt_o !== 4'b0001) begin errors++; $display("FAIL mid_next gnt=%b exp 0001", gnt_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_ni = ($urandom_range(0, 299) != 0);
      for (int b = 0; b < NR; b++)
        if ($urandom_range(0, 15) == 0) req_i[b] = ~req_i[b];
      req_vector_i = {$urandom, $urandom};
      monitor_i = ($urandom_range(0, 7) == 0) ? NRU'($urandom) : '0;
      viol_ready_i = $urandom_range(0, 2) == 0;
      cycle();
      checks++;
      if (dut_bus !== exp_bus) begin errors++; $display("FAIL model_rand c=%0d dut=%h exp=%h", c, dut_bus, exp_bus); end
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_slicing();
    test_rr_wrap();
    test_lone_owner();
    test_violations();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
